// File: rtl/mux_sync_dst_mc_if.sv
// Source-to-destination bundle for mux_sync_dst_mc: per-channel request, held data,
// consumer handshake and overrun control.
interface mux_sync_dst_mc_if #(
  parameter int unsigned DWIDTH = 4,
  parameter int unsigned NCH    = 2
);
  logic [NCH-1:0]        i_async_req;
  logic [NCH*DWIDTH-1:0] i_async_data;
  logic [NCH-1:0]        i_ready;
  logic [NCH-1:0]        i_ovf_clr;
  logic [NCH*DWIDTH-1:0] o_data;
  logic [NCH-1:0]        o_valid;
  logic [NCH-1:0]        o_ack;
  logic [NCH-1:0]        o_ovf;

  modport master (
    output i_async_req, i_async_data, i_ready, i_ovf_clr,
    input  o_data, o_valid, o_ack, o_ovf
  );

  modport slave (
    input  i_async_req, i_async_data, i_ready, i_ovf_clr,
    output o_data, o_valid, o_ack, o_ovf
  );
endinterface

// File: rtl/mux_sync_dst_mc.sv
// Multi-channel destination-side mux synchroniser: synchronises each request, captures the
// held source word on an event, presents it valid/ready, acks the source and flags overruns.
module mux_sync_dst_mc #(
  parameter int unsigned DWIDTH      = 4,
  parameter int unsigned NCH         = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MODE        = 0
) (
  input  logic             i_clk,
  input  logic             rst,
  mux_sync_dst_mc_if.slave bus
);

  localparam int unsigned     CntW       = $clog2(SYNC_STAGES + 2);
  localparam logic [CntW-1:0] SettleInit = CntW'(SYNC_STAGES + 1);

  logic [NCH-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
  logic [NCH-1:0]                  hreq_q, hreq_d;
  logic [NCH-1:0]                  event_q, event_d;
  logic [NCH-1:0]                  valid_q, valid_d;
  logic [NCH-1:0]                  ack_q, ack_d;
  logic [NCH-1:0]                  ovf_q, ovf_d;
  logic [NCH-1:0][DWIDTH-1:0]      data_q, data_d;
  logic [CntW-1:0]                 settle_q, settle_d;
  logic [NCH-1:0]                  sreq, xfer, edge_det;

  always_comb begin
    settle_d = settle_q;
    if (settle_q != '0) begin
      settle_d = settle_q - 1'b1;
    end
    sync_d   = sync_q;
    hreq_d   = hreq_q;
    event_d  = '0;
    valid_d  = valid_q;
    ack_d    = ack_q;
    ovf_d    = ovf_q;
    data_d   = data_q;
    sreq     = '0;
    xfer     = '0;
    edge_det = '0;

    for (int c = 0; c < NCH; c++) begin
      sync_d[c]   = {sync_q[c][SYNC_STAGES-2:0], bus.i_async_req[c]};
      sreq[c]     = sync_q[c][SYNC_STAGES-1];
      hreq_d[c]   = sreq[c];
      edge_det[c] = (MODE == 0) ? (sreq[c] ^ hreq_q[c]) : (sreq[c] & ~hreq_q[c]);
      // History keeps tracking during settle; only the event itself is masked.
      event_d[c]  = (settle_q == '0) & edge_det[c];
      xfer[c]     = valid_q[c] & bus.i_ready[c];

      if (event_q[c] && (!valid_q[c] || bus.i_ready[c])) begin
        data_d[c]  = bus.i_async_data[c*DWIDTH +: DWIDTH];
        valid_d[c] = 1'b1;
      end else if (xfer[c]) begin
        valid_d[c] = 1'b0;
      end

      // Overrun drops the new sample; set beats clear.
      if (event_q[c] && valid_q[c] && !bus.i_ready[c]) begin
        ovf_d[c] = 1'b1;
      end else if (bus.i_ovf_clr[c]) begin
        ovf_d[c] = 1'b0;
      end

      if (MODE == 0) begin
        if (xfer[c]) begin
          ack_d[c] = ~ack_q[c];
        end
      end else if (xfer[c]) begin
        ack_d[c] = 1'b1;
      end else if (ack_q[c] && !sreq[c]) begin
        ack_d[c] = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (rst) begin
      sync_q   <= '0;
      hreq_q   <= '0;
      event_q  <= '0;
      valid_q  <= '0;
      ack_q    <= '0;
      ovf_q    <= '0;
      data_q   <= '0;
      settle_q <= SettleInit;
    end else begin
      sync_q   <= sync_d;
      hreq_q   <= hreq_d;
      event_q  <= event_d;
      valid_q  <= valid_d;
      ack_q    <= ack_d;
      ovf_q    <= ovf_d;
      data_q   <= data_d;
      settle_q <= settle_d;
    end
  end

  assign bus.o_data  = data_q;
  assign bus.o_valid = valid_q;
  assign bus.o_ack   = ack_q;
  assign bus.o_ovf   = ovf_q;

endmodule

// File: tb/tb_mux_sync_dst_mc.sv
// Bench for mux_sync_dst_mc: a two-phase (dut0) and a four-phase (dut1) instance checked
// every cycle against a sample-history reference model.
module tb_mux_sync_dst_mc;
  localparam int DW = 4;
  localparam int NC = 2;
  localparam int SS = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NC-1:0]    req [2];
  logic [NC-1:0]    rdy [2];
  logic [NC-1:0]    clr [2];
  logic [NC*DW-1:0] dat [2];
  logic [NC-1:0]    ov  [2];
  logic [NC-1:0]    oa  [2];
  logic [NC-1:0]    oo  [2];
  logic [NC*DW-1:0] od  [2];

  // Reference model state
  logic [NC-1:0]    mv [2];
  logic [NC-1:0]    ma [2];
  logic [NC-1:0]    mo [2];
  logic [NC*DW-1:0] md [2];
  logic [7:0]       hist [2][NC];
  int pc;
  int nchk = 0;
  int nerr = 0;

  mux_sync_dst_mc_if #(.DWIDTH(DW), .NCH(NC)) bus0 ();
  mux_sync_dst_mc_if #(.DWIDTH(DW), .NCH(NC)) bus1 ();

  assign bus0.i_async_req  = req[0];
  assign bus0.i_async_data = dat[0];
  assign bus0.i_ready      = rdy[0];
  assign bus0.i_ovf_clr    = clr[0];
  assign bus1.i_async_req  = req[1];
  assign bus1.i_async_data = dat[1];
  assign bus1.i_ready      = rdy[1];
  assign bus1.i_ovf_clr    = clr[1];
  assign ov[0] = bus0.o_valid;
  assign oa[0] = bus0.o_ack;
  assign oo[0] = bus0.o_ovf;
  assign od[0] = bus0.o_data;
  assign ov[1] = bus1.o_valid;
  assign oa[1] = bus1.o_ack;
  assign oo[1] = bus1.o_ovf;
  assign od[1] = bus1.o_data;

  mux_sync_dst_mc #(.DWIDTH(DW), .NCH(NC), .SYNC_STAGES(SS), .MODE(0)) dut0 (
    .i_clk(clk), .rst(rst), .bus(bus0)
  );
  mux_sync_dst_mc #(.DWIDTH(DW), .NCH(NC), .SYNC_STAGES(SS), .MODE(1)) dut1 (
    .i_clk(clk), .rst(rst), .bus(bus1)
  );

  // Advance one posedge. hist bit j is the request sampled j+1 posedges before edge n.
  // A change first sampled at posedge k is captured at k+SS+1; an edge whose compare
  // cycle falls inside the settle window (n < SS+3 after reset) is ignored.
  task automatic step();
    int   n;
    logic ev, xf, s_new, s_old, s_cur;
    n = pc + 1;
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < NC; c++) begin
        if (rst) begin
          mv[d][c] = 1'b0;
          ma[d][c] = 1'b0;
          mo[d][c] = 1'b0;
          md[d][c*DW +: DW] = '0;
          hist[d][c] = '0;
        end else begin
          s_cur = hist[d][c][SS-1];
          s_new = hist[d][c][SS];
          s_old = hist[d][c][SS+1];
          ev = (n >= SS + 3) && ((d == 0) ? (s_new != s_old) : (s_new && !s_old));
          xf = mv[d][c] && rdy[d][c];
          if (d == 0) begin
            if (xf) ma[d][c] = !ma[d][c];
          end else if (xf) begin
            ma[d][c] = 1'b1;
          end else if (ma[d][c] && !s_cur) begin
            ma[d][c] = 1'b0;
          end
          if (ev && mv[d][c] && !rdy[d][c]) mo[d][c] = 1'b1;
          else if (clr[d][c]) mo[d][c] = 1'b0;
          if (ev && (!mv[d][c] || rdy[d][c])) begin
            md[d][c*DW +: DW] = dat[d][c*DW +: DW];
            mv[d][c] = 1'b1;
          end else if (xf) begin
            mv[d][c] = 1'b0;
          end
          hist[d][c] = {hist[d][c][6:0], req[d][c]};
        end
      end
    end
    pc = rst ? 0 : n;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req[d] = '0; rdy[d] = '0; clr[d] = '0; dat[d] = '0;
    end
    step();
    step();
    for (int d = 0; d < 2; d++) begin
      nchk++;
      if ({ov[d], oa[d], oo[d], od[d]} !== '0) begin
        nerr++;
        $display("FAIL reset_state dut%0d: got v=%b a=%b o=%b d=%h want all 0",
                 d, ov[d], oa[d], oo[d], od[d]);
      end
    end
    rst = 1'b0;
    repeat (8) begin
      step();
      for (int d = 0; d < 2; d++) begin
        nchk++;
        if ({ov[d], oa[d], oo[d]} !== {mv[d], ma[d], mo[d]}) begin
          nerr++;
          $display("FAIL reset_flags dut%0d: got %b want %b", d,
                   {ov[d], oa[d], oo[d]}, {mv[d], ma[d], mo[d]});
        end
        nchk++;
        if (od[d] !== md[d]) begin
          nerr++;
          $display("FAIL reset_data dut%0d: got %h want %h", d, od[d], md[d]);
        end
      end
    end
  endtask

  task automatic test_basic_toggle();
    logic a0;
    rdy[0] = 2'b11;
    rdy[1] = 2'b11;
    dat[0][3:0] = 4'h5;
    a0 = oa[0][0];
    req[0][0] = ~req[0][0];
    for (int i = 0; i < 7; i++) begin
      step();
      for (int d = 0; d < 2; d++) begin
        nchk++;
        if ({ov[d], oa[d], oo[d]} !== {mv[d], ma[d], mo[d]}) begin
          nerr++;
          $display("FAIL basic_flags dut%0d: got %b want %b", d,
                   {ov[d], oa[d], oo[d]}, {mv[d], ma[d], mo[d]});
        end
        nchk++;
        if (od[d] !== md[d]) begin
          nerr++;
          $display("FAIL basic_data dut%0d: got %h want %h", d, od[d], md[d]);
        end
      end
      if (i == 2) begin
        nchk++;
        if (ov[0][0] !== 1'b0) begin
          nerr++;
          $display("FAIL basic_early_valid: got %b want 0", ov[0][0]);
        end
      end
      if (i == 3) begin
        nchk++;
        if ({ov[0], od[0][3:0]} !== {2'b01, 4'h5}) begin
          nerr++;
          $display("FAIL basic_capture: got valid=%b data=%h want valid=01 data=5",
                   ov[0], od[0][3:0]);
        end
      end
      if (i == 4) begin
        nchk++;
        if ({ov[0][0], oa[0][0]} !== {1'b0, ~a0}) begin
          nerr++;
          $display("FAIL basic_ack_toggle: got valid=%b ack=%b want valid=0 ack=%b",
                   ov[0][0], oa[0][0], ~a0);
        end
      end
    end
  endtask

  task automatic test_reset_held();
    req[0] = 2'b11;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    repeat (12) begin
      step();
      nchk++;
      if ({ov[0], oa[0], oo[0]} !== 6'b0) begin
        nerr++;
        $display("FAIL held_req_spurious: got v=%b a=%b o=%b want all 0", ov[0], oa[0], oo[0]);
      end
      for (int d = 0; d < 2; d++) begin
        nchk++;
        if ({ov[d], oa[d], oo[d]} !== {mv[d], ma[d], mo[d]}) begin
          nerr++;
          $display("FAIL held_flags dut%0d: got %b want %b", d,
                   {ov[d], oa[d], oo[d]}, {mv[d], ma[d], mo[d]});
        end
      end
    end
  endtask

  task automatic test_overrun();
    rdy[0] = 2'b01;
    for (int w = 0; w < 2; w++) begin
      dat[0][7:4] = (w == 0) ? 4'h3 : 4'h9;
      req[0][1] = ~req[0][1];
      repeat (w == 0 ? 5 : 6) begin
        step();
        for (int d = 0; d < 2; d++) begin
          nchk++;
          if ({ov[d], oa[d], oo[d]} !== {mv[d], ma[d], mo[d]}) begin
            nerr++;
            $display("FAIL ovr_flags dut%0d: got %b want %b", d,
                     {ov[d], oa[d], oo[d]}, {mv[d], ma[d], mo[d]});
          end
          nchk++;
          if (od[d] !== md[d]) begin
            nerr++;
            $display("FAIL ovr_data dut%0d: got %h want %h", d, od[d], md[d]);
          end
        end
      end
    end
    nchk++;
    if ({ov[0][1], oo[0][1], od[0][7:4]} !== {2'b11, 4'h3}) begin
      nerr++;
      $display("FAIL ovr_retain: got valid=%b ovf=%b data=%h want 1 1 3",
               ov[0][1], oo[0][1], od[0][7:4]);
    end
    rdy[0][1] = 1'b1;
    repeat (3) begin
      step();
      nchk++;
      if ({ov[0][1], oo[0][1]} !== {mv[0][1], mo[0][1]}) begin
        nerr++;
        $display("FAIL ovr_drain: got v/o=%b%b want %b%b", ov[0][1], oo[0][1], mv[0][1], mo[0][1]);
      end
    end
    nchk++;
    if ({ov[0][1], oo[0][1]} !== 2'b01) begin
      nerr++;
      $display("FAIL ovr_single_xfer: got valid=%b ovf=%b want 0 1", ov[0][1], oo[0][1]);
    end
    clr[0][1] = 1'b1;
    step();
    clr[0][1] = 1'b0;
    nchk++;
    if (oo[0][1] !== 1'b0) begin
      nerr++;
      $display("FAIL ovr_clear: got %b want 0", oo[0][1]);
    end
  endtask

  task automatic test_same_cycle();
    rdy[0][0] = 1'b0;
    for (int w = 0; w < 2; w++) begin
      dat[0][3:0] = (w == 0) ? 4'hA : 4'hB;
      req[0][0] = ~req[0][0];
      for (int i = 0; i < 5; i++) begin
        if (w == 1 && i == 3) rdy[0][0] = 1'b1;
        step();
        for (int d = 0; d < 2; d++) begin
          nchk++;
          if ({ov[d], oa[d], oo[d]} !== {mv[d], ma[d], mo[d]}) begin
            nerr++;
            $display("FAIL same_flags dut%0d: got %b want %b", d,
                     {ov[d], oa[d], oo[d]}, {mv[d], ma[d], mo[d]});
          end
          nchk++;
          if (od[d] !== md[d]) begin
            nerr++;
            $display("FAIL same_data dut%0d: got %h want %h", d, od[d], md[d]);
          end
        end
        if (w == 1 && i == 3) begin
          nchk++;
          if ({ov[0][0], oo[0][0], od[0][3:0]} !== {2'b10, 4'hB}) begin
            nerr++;
            $display("FAIL same_cycle_capture: got valid=%b ovf=%b data=%h want 1 0 b",
                     ov[0][0], oo[0][0], od[0][3:0]);
          end
        end
      end
    end
  endtask

  task automatic test_fourphase();
    int sent [NC];
    int ph [NC];
    int rx [NC][$];
    int cyc;
    bit done;
    for (int c = 0; c < NC; c++) begin
      sent[c] = 0;
      ph[c] = 0;
    end
    req[1] = '0;
    cyc = 0;
    done = 1'b0;
    while (!done && cyc < 3000) begin
      rdy[1] = NC'($urandom_range(0, 3));
      for (int c = 0; c < NC; c++) begin
        case (ph[c])
          0: if (sent[c] < 10) begin
            sent[c]++;
            dat[1][c*DW +: DW] = DW'(sent[c]);
            req[1][c] = 1'b1;
            ph[c] = 1;
          end
          1: if (oa[1][c]) begin
            req[1][c] = 1'b0;
            ph[c] = 2;
          end
          default: if (!oa[1][c]) ph[c] = 0;
        endcase
        if (ov[1][c] && rdy[1][c]) rx[c].push_back(int'(od[1][c*DW +: DW]));
      end
      step();
      cyc++;
      for (int d = 0; d < 2; d++) begin
        nchk++;
        if ({ov[d], oa[d], oo[d]} !== {mv[d], ma[d], mo[d]}) begin
          nerr++;
          $display("FAIL fourphase_flags dut%0d cyc%0d: got %b want %b", d, cyc,
                   {ov[d], oa[d], oo[d]}, {mv[d], ma[d], mo[d]});
        end
        nchk++;
        if (od[d] !== md[d]) begin
          nerr++;
          $display("FAIL fourphase_data dut%0d: got %h want %h", d, od[d], md[d]);
        end
      end
      done = (sent[0] == 10) && (sent[1] == 10) && (ph[0] == 0) && (ph[1] == 0);
    end
    nchk++;
    if (!done) begin
      nerr++;
      $display("FAIL fourphase_timeout: got sent=%0d/%0d want 10/10 within 3000 cycles",
               sent[0], sent[1]);
    end
    for (int c = 0; c < NC; c++) begin
      nchk++;
      if (rx[c].size() != 10) begin
        nerr++;
        $display("FAIL fourphase_count ch%0d: got %0d want 10", c, rx[c].size());
      end
      for (int i = 0; i < rx[c].size() && i < 10; i++) begin
        nchk++;
        if (rx[c][i] != i + 1) begin
          nerr++;
          $display("FAIL fourphase_order ch%0d[%0d]: got %0d want %0d", c, i, rx[c][i], i + 1);
        end
      end
    end
    nchk++;
    if (oo[1] !== 2'b00) begin
      nerr++;
      $display("FAIL fourphase_ovf: got %b want 00", oo[1]);
    end
  endtask

  task automatic test_reset_mid();
    rdy[0] = 2'b11;
    if (oa[0][0] !== 1'b1) begin
      dat[0][3:0] = 4'h1;
      req[0][0] = ~req[0][0];
      repeat (6) step();
    end
    rdy[0][0] = 1'b0;
    dat[0][3:0] = 4'hC;
    req[0][0] = ~req[0][0];
    repeat (5) begin
      step();
      nchk++;
      if ({ov[0], oa[0], oo[0]} !== {mv[0], ma[0], mo[0]}) begin
        nerr++;
        $display("FAIL mid_flags: got %b want %b", {ov[0], oa[0], oo[0]}, {mv[0], ma[0], mo[0]});
      end
    end
    nchk++;
    if ({ov[0][0], oa[0][0]} !== 2'b11) begin
      nerr++;
      $display("FAIL mid_prereq: got valid=%b ack=%b want 1 1", ov[0][0], oa[0][0]);
    end
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req[d] = '0;
      dat[d] = '0;
    end
    step();
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      nchk++;
      if ({ov[d], oa[d], oo[d], od[d]} !== '0) begin
        nerr++;
        $display("FAIL mid_reset dut%0d: got v=%b a=%b o=%b d=%h want all 0",
                 d, ov[d], oa[d], oo[d], od[d]);
      end
    end
    rdy[0] = 2'b11;
    repeat (6) step();
    dat[0][3:0] = 4'h6;
    req[0][0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      nchk++;
      if ({ov[0], oa[0], oo[0], od[0]} !== {mv[0], ma[0], mo[0], md[0]}) begin
        nerr++;
        $display("FAIL mid_fresh: got %b/%h want %b/%h", {ov[0], oa[0], oo[0]}, od[0],
                 {mv[0], ma[0], mo[0]}, md[0]);
      end
      if (i == 3) begin
        nchk++;
        if ({ov[0][0], od[0][3:0]} !== {1'b1, 4'h6}) begin
          nerr++;
          $display("FAIL mid_fresh_capture: got valid=%b data=%h want 1 6", ov[0][0], od[0][3:0]);
        end
      end
    end
  endtask

  initial begin
    pc = 0;
    test_reset();
    test_basic_toggle();
    test_reset_held();
    test_overrun();
    test_same_cycle();
    test_fourphase();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
